// File: rtl/rm_unshape.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | rm_unshape : unpacks 128-bit result rows into densely packed 32-bit words |
// | Revision   : 1.0                                                          |
// +---------------------------------------------------------------------------+
module rm_unshape #(
  parameter logic [31:0] SADDR_R_MEM = 32'h0,
  parameter logic [31:0] R_MEM_INCR  = 32'd4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  M,
  input  logic [15:0]  P,
  input  logic         unshape_start,
  output logic         unshape_finish,
  output logic [15:0]  BRAM_RM128_raddr,
  input  logic [127:0] BRAM_RM128_rddata,
  output logic         BRAM_RM32_clk,
  output logic         BRAM_RM32_rst,
  output logic         BRAM_RM32_en,
  output logic [3:0]   BRAM_RM32_we,
  output logic [31:0]  BRAM_RM32_addr,
  output logic [31:0]  BRAM_RM32_wrdata
);

  typedef enum logic [5:0] {
    S_IDLE = 6'b000001,
    S_COM  = 6'b000010,
    S_RD   = 6'b000100,
    S_LAT  = 6'b001000,
    S_WR   = 6'b010000,
    S_FIN  = 6'b100000
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic [15:0]  r_m;
  logic [15:0]  r_p;
  logic [15:0]  r_wpr;
  logic [15:0]  r_row_cnt;
  logic [15:0]  r_wcol_cnt;
  logic [1:0]   r_lane_cnt;
  logic [2:0]   r_nvalid;
  logic [127:0] r_buf;
  logic         r_finish;
  logic [15:0]  r_raddr;
  logic [31:0]  r_addr;

  logic [15:0]  w_wpr;
  logic [16:0]  w_rem;
  logic [2:0]   w_nvalid;
  logic         w_last_lane;
  logic         w_last_wcol;
  logic         w_last_row;

  // Only meaningful for P >= 1; P == 0 bypasses the datapath entirely.
  assign w_wpr       = ((P - 16'd1) >> 2) + 16'd1;
  assign w_rem       = {1'b0, r_p} - {1'b0, r_wcol_cnt[13:0], 2'b00};
  assign w_nvalid    = (w_rem >= 17'd4) ? 3'd4 : w_rem[2:0];
  assign w_last_lane = ({1'b0, r_lane_cnt} == (r_nvalid - 3'd1));
  assign w_last_wcol = (r_wcol_cnt == (r_wpr - 16'd1));
  assign w_last_row  = (r_row_cnt == (r_m - 16'd1));

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    BRAM_RM32_we = 4'h0;
    case (r_state)
      S_IDLE: if (unshape_start) w_next = S_COM;
      S_COM:  w_next = ((M == 16'd0) || (P == 16'd0)) ? S_FIN : S_RD;
      S_RD:   w_next = S_LAT;
      S_LAT:  w_next = S_WR;
      S_WR: begin
        BRAM_RM32_we = 4'hF;
        if (w_last_lane) w_next = (w_last_row && w_last_wcol) ? S_FIN : S_RD;
      end
      S_FIN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_m        <= 16'd0;
      r_p        <= 16'd0;
      r_wpr      <= 16'd0;
      r_row_cnt  <= 16'd0;
      r_wcol_cnt <= 16'd0;
      r_lane_cnt <= 2'd0;
      r_nvalid   <= 3'd0;
      r_buf      <= 128'd0;
      r_finish   <= 1'b0;
      r_raddr    <= 16'd0;
      r_addr     <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: if (unshape_start) r_finish <= 1'b0;
        S_COM: begin
          r_m        <= M;
          r_p        <= P;
          r_wpr      <= w_wpr;
          r_row_cnt  <= 16'd0;
          r_wcol_cnt <= 16'd0;
          r_lane_cnt <= 2'd0;
          r_raddr    <= 16'd0;
          r_addr     <= SADDR_R_MEM;
        end
        S_LAT: begin
          r_buf    <= BRAM_RM128_rddata;
          r_nvalid <= w_nvalid;
        end
        S_WR: begin
          r_addr <= r_addr + R_MEM_INCR;
          if (w_last_lane) begin
            r_lane_cnt <= 2'd0;
            r_raddr    <= r_raddr + 16'd1;
            if (w_last_wcol) begin
              r_wcol_cnt <= 16'd0;
              r_row_cnt  <= r_row_cnt + 16'd1;
            end else begin
              r_wcol_cnt <= r_wcol_cnt + 16'd1;
            end
          end else begin
            r_lane_cnt <= r_lane_cnt + 2'd1;
          end
        end
        S_FIN: r_finish <= 1'b1;
        default: ;
      endcase
    end
  end

  assign unshape_finish   = r_finish;
  assign BRAM_RM128_raddr = r_raddr;
  assign BRAM_RM32_clk    = clk;
  assign BRAM_RM32_rst    = ~rst;
  assign BRAM_RM32_en     = 1'b1;
  assign BRAM_RM32_addr   = r_addr;
  assign BRAM_RM32_wrdata = r_buf[{r_lane_cnt, 5'b00000} +: 32];

endmodule
`default_nettype wire

// File: tb/tb_rm_unshape.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_rm_unshape : randomized self-checking bench with a row/column model    |
// | Revision      : 1.0                                                       |
// +---------------------------------------------------------------------------+
module tb_rm_unshape;

  logic         clk;
  logic         rst;
  logic [15:0]  tb_m;
  logic [15:0]  tb_p;
  logic         tb_start;
  logic         unshape_finish;
  logic [15:0]  BRAM_RM128_raddr;
  logic [127:0] BRAM_RM128_rddata;
  logic         BRAM_RM32_clk;
  logic         BRAM_RM32_rst;
  logic         BRAM_RM32_en;
  logic [3:0]   BRAM_RM32_we;
  logic [31:0]  BRAM_RM32_addr;
  logic [31:0]  BRAM_RM32_wrdata;

  logic [127:0] mem128 [0:255];
  logic [63:0]  wq [$];
  int           n_chk;
  int           n_err;

  rm_unshape dut (
    .clk               (clk),
    .rst               (rst),
    .M                 (tb_m),
    .P                 (tb_p),
    .unshape_start     (tb_start),
    .unshape_finish    (unshape_finish),
    .BRAM_RM128_raddr  (BRAM_RM128_raddr),
    .BRAM_RM128_rddata (BRAM_RM128_rddata),
    .BRAM_RM32_clk     (BRAM_RM32_clk),
    .BRAM_RM32_rst     (BRAM_RM32_rst),
    .BRAM_RM32_en      (BRAM_RM32_en),
    .BRAM_RM32_we      (BRAM_RM32_we),
    .BRAM_RM32_addr    (BRAM_RM32_addr),
    .BRAM_RM32_wrdata  (BRAM_RM32_wrdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency read port of the 128-bit result buffer.
  always @(posedge clk) BRAM_RM128_rddata <= mem128[BRAM_RM128_raddr[7:0]];

  always @(negedge clk) begin
    if (BRAM_RM32_we != 4'h0) wq.push_back({BRAM_RM32_addr, BRAM_RM32_wrdata});
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_rand(input int nwords);
    for (int i = 0; i < nwords; i++)
      mem128[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Runs one job and compares against a row-major element model.
  task automatic run_case(input int m, input int p, input bit pulse_again);
    int         wpr;
    int         cyc;
    int         exp_cyc;
    int         nexp;
    int         n0;
    logic [63:0] exp_q [$];
    wpr = (p + 3) / 4;
    exp_q.delete();
    if (m > 0 && p > 0) begin
      for (int r = 0; r < m; r++)
        for (int c = 0; c < p; c++)
          exp_q.push_back({32'(4 * (r * p + c)), mem128[r * wpr + c / 4][32 * (c % 4) +: 32]});
      exp_cyc = 3 + m * (2 * wpr + p);
    end else begin
      exp_cyc = 3;
    end
    nexp = exp_q.size();

    @(negedge clk);
    tb_m = 16'(m);
    tb_p = 16'(p);
    tb_start = 1'b1;
    wq.delete();
    @(negedge clk);
    tb_start = 1'b0;
    cyc = 1;
    while (!unshape_finish && cyc < 5000) begin
      tb_start = pulse_again && (cyc == 4);
      @(negedge clk);
      cyc++;
    end
    tb_start = 1'b0;
    chk_eq($sformatf("cycles m%0d p%0d", m, p), 64'(cyc), 64'(exp_cyc));
    chk_eq($sformatf("wcount m%0d p%0d", m, p), 64'(wq.size()), 64'(nexp));
    for (int i = 0; i < nexp && i < wq.size(); i++)
      chk_eq($sformatf("write%0d m%0d p%0d", i, m, p), wq[i], exp_q[i]);
    chk_eq("raddr_end", 64'(BRAM_RM128_raddr), 64'((m > 0 && p > 0) ? (m * wpr) % 65536 : 0));
    n0 = wq.size();
    repeat (3) @(negedge clk);
    chk_eq("finish_held", 64'(unshape_finish), 64'd1);
    chk_eq("no_extra_writes", 64'(wq.size()), 64'(n0));
  endtask

  initial begin
    int k;
    n_chk = 0;
    n_err = 0;
    rst = 1'b0;
    tb_m = 16'd0;
    tb_p = 16'd0;
    tb_start = 1'b0;
    for (int i = 0; i < 256; i++) mem128[i] = 128'd0;
    repeat (3) @(negedge clk);
    chk_eq("rst_finish", 64'(unshape_finish), 64'd0);
    chk_eq("rst_we", 64'(BRAM_RM32_we), 64'd0);
    chk_eq("rst_raddr", 64'(BRAM_RM128_raddr), 64'd0);
    chk_eq("rst_addr", 64'(BRAM_RM32_addr), 64'd0);
    chk_eq("rst_wrdata", 64'(BRAM_RM32_wrdata), 64'd0);
    chk_eq("rst_bram_rst", 64'(BRAM_RM32_rst), 64'd1);
    chk_eq("bram_en", 64'(BRAM_RM32_en), 64'd1);
    rst = 1'b1;
    @(negedge clk);

    // T1
    mem128[0] = {32'd4, 32'd3, 32'd2, 32'd1};
    run_case(1, 4, 1'b0);
    // T2 with padding lanes carrying visible garbage
    mem128[0] = {32'd4, 32'd3, 32'd2, 32'd1};
    mem128[1] = {32'hDEADBEEF, 32'hDEADBEEF, 32'd6, 32'd5};
    mem128[2] = {32'hA, 32'h9, 32'h8, 32'h7};
    mem128[3] = {32'hDEADBEEF, 32'hDEADBEEF, 32'hC, 32'hB};
    run_case(2, 6, 1'b0);
    // T6: same job with a stray start mid-run
    run_case(2, 6, 1'b1);
    // T3, T4
    fill_rand(8);
    run_case(3, 1, 1'b0);
    run_case(0, 5, 1'b0);
    run_case(2, 0, 1'b0);

    // T5: reset in the middle of a write burst
    fill_rand(8);
    @(negedge clk);
    tb_m = 16'd2;
    tb_p = 16'd6;
    tb_start = 1'b1;
    @(negedge clk);
    tb_start = 1'b0;
    k = 0;
    while (BRAM_RM32_we != 4'hF && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk_eq("t5_reached_wr", 64'(BRAM_RM32_we), 64'hF);
    rst = 1'b0;
    @(negedge clk);
    chk_eq("t5_we", 64'(BRAM_RM32_we), 64'd0);
    chk_eq("t5_finish", 64'(unshape_finish), 64'd0);
    chk_eq("t5_addr", 64'(BRAM_RM32_addr), 64'd0);
    rst = 1'b1;
    run_case(2, 6, 1'b0);

    // Randomized jobs
    for (int t = 0; t < 8; t++) begin
      int m;
      int p;
      m = $urandom_range(1, 5);
      p = $urandom_range(1, 11);
      fill_rand(m * ((p + 3) / 4));
      run_case(m, p, ($urandom_range(0, 1) == 1));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
